// File: rtl/avg_pipe.sv
// avg_pipe: registered multi-channel adder tree followed by a block
// accumulator that emits the mean of 2^acc_log summed vectors.
// Stages: input register, LOG2C tree levels, accumulate/output stage.
module avg_pipe #(
    parameter int WIDTH       = 16,
    parameter int CHANNELS    = 8,
    parameter int MAX_ACC_LOG = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic [CHANNELS*WIDTH-1:0]            in_data,
    input  logic [$clog2(MAX_ACC_LOG+1)-1:0]     acc_log,
    input  logic                                 round_en,
    input  logic                                 clr,
    output logic                                 out_valid,
    output logic [WIDTH-1:0]                     avg,
    output logic                                 busy
);

    localparam int LOG2C = $clog2(CHANNELS);
    localparam int AW    = $clog2(MAX_ACC_LOG + 1);
    localparam int SW    = WIDTH + LOG2C;
    localparam int ACCW  = SW + MAX_ACC_LOG;
    localparam int CW    = (MAX_ACC_LOG > 0) ? MAX_ACC_LOG : 1;
    localparam int NODES = 2 * CHANNELS - 1;

    // Flat node storage: level j occupies [2C - 2C>>j, +C>>j); the root is last.
    logic [SW-1:0]    node_reg [NODES];
    logic [LOG2C:0]   vld_reg;

    logic [ACCW-1:0]  acc_reg;
    logic [CW-1:0]    count_reg;
    logic [AW-1:0]    log_reg;
    logic             rnd_reg;
    logic [WIDTH-1:0] avg_reg;
    logic             out_valid_reg;

    genvar gi, gj;

    // Input register: each channel zero-extended to the tree width.
    generate
        for (gj = 0; gj < CHANNELS; gj++) begin : g_in
            // Capture one channel of the incoming vector.
            always_ff @(posedge clk) begin
                node_reg[gj] <= SW'(in_data[gj*WIDTH +: WIDTH]);
            end
        end

        for (gi = 1; gi <= LOG2C; gi++) begin : g_level
            localparam int SRC = 2 * CHANNELS - ((2 * CHANNELS) >> (gi - 1));
            localparam int DST = 2 * CHANNELS - ((2 * CHANNELS) >> gi);
            localparam int N   = CHANNELS >> gi;
            for (gj = 0; gj < N; gj++) begin : g_node
                // Pairwise sum of two nodes from the previous level.
                always_ff @(posedge clk) begin
                    node_reg[DST+gj] <= node_reg[SRC+2*gj] + node_reg[SRC+2*gj+1];
                end
            end
        end
    endgenerate

    // Valid token shift register travelling alongside the tree data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_reg <= '0;
        end else begin
            vld_reg <= {vld_reg[LOG2C-1:0], in_valid};
        end
    end

    logic [SW-1:0]   tree_sum;
    logic            tree_vld;
    logic [AW-1:0]   log_clamped;
    logic [AW-1:0]   eff_log;
    logic            eff_rnd;
    logic            start;
    logic [ACCW-1:0] acc_base;
    logic [ACCW-1:0] acc_sum;
    logic [ACCW-1:0] total;
    logic [CW-1:0]   cnt_base;
    logic [CW-1:0]   last_cnt;
    logic            last_vec;

    assign tree_sum = node_reg[NODES-1];
    assign tree_vld = vld_reg[LOG2C];

    // Resolve the block mode (fresh latch on block start or clear) and the final-vector sum.
    always_comb begin
        log_clamped = (acc_log > AW'(MAX_ACC_LOG)) ? AW'(MAX_ACC_LOG) : acc_log;
        start       = clr || (count_reg == '0);
        eff_log     = start ? log_clamped : log_reg;
        eff_rnd     = start ? round_en : rnd_reg;
        acc_base    = clr ? '0 : acc_reg;
        cnt_base    = clr ? '0 : count_reg;
        last_cnt    = CW'((1 << eff_log) - 1);
        last_vec    = (cnt_base == last_cnt);
        acc_sum     = acc_base + ACCW'(tree_sum);
        total       = acc_sum + (eff_rnd ? (ACCW'(1) << (LOG2C + eff_log - 1)) : '0);
    end

    // Accumulate/output stage: accumulate, or finish the block and publish the mean.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_reg       <= '0;
            count_reg     <= '0;
            log_reg       <= '0;
            rnd_reg       <= 1'b0;
            avg_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= 1'b0;
            if (tree_vld) begin
                if (start) begin
                    log_reg <= eff_log;
                    rnd_reg <= eff_rnd;
                end
                if (last_vec) begin
                    avg_reg       <= WIDTH'(total >> (LOG2C + eff_log));
                    out_valid_reg <= 1'b1;
                    acc_reg       <= '0;
                    count_reg     <= '0;
                end else begin
                    acc_reg   <= acc_sum;
                    count_reg <= cnt_base + CW'(1);
                end
            end else if (clr) begin
                acc_reg   <= '0;
                count_reg <= '0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign avg       = avg_reg;
    assign busy      = (count_reg != '0);

endmodule

// File: tb/tb_avg_pipe.sv
// Bench for avg_pipe: directed scenarios followed by random traffic, all
// compared every cycle against a block-level reference model.
module tb_avg_pipe;

    localparam int W     = 16;
    localparam int C     = 8;
    localparam int M     = 4;
    localparam int LC    = 3;
    localparam int DEPTH = LC + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic [C*W-1:0] in_data = '0;
    logic [2:0]     acc_log = '0;
    logic           round_en = 1'b0;
    logic           clr = 1'b0;
    logic           out_valid;
    logic [W-1:0]   avg;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ch [C];

    // reference model state
    bit           pv [DEPTH];
    longint       ps [DEPTH];
    longint       blk [$];
    int           blk_l;
    bit           blk_r;
    logic [W-1:0] exp_avg = '0;
    bit           exp_ov = 1'b0;

    avg_pipe #(.WIDTH(W), .CHANNELS(C), .MAX_ACC_LOG(M)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .acc_log  (acc_log),
        .round_en (round_en),
        .clr      (clr),
        .out_valid(out_valid),
        .avg      (avg),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // One clock: pack inputs, advance the model, take the edge, compare.
    task automatic tick();
        bit     v;
        longint s;
        longint vsum;
        longint total;
        int     sh;
        vsum = 0;
        for (int k = 0; k < C; k++) begin
            in_data[k*W +: W] = ch[k];
            vsum += longint'(ch[k]);
        end
        v = pv[DEPTH-1];
        s = ps[DEPTH-1];
        if (rst == 1'b0) begin
            for (int i = 0; i < DEPTH; i++) pv[i] = 1'b0;
            blk.delete();
            exp_avg = '0;
            exp_ov  = 1'b0;
        end else begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                pv[i] = pv[i-1];
                ps[i] = ps[i-1];
            end
            pv[0]  = in_valid;
            ps[0]  = vsum;
            exp_ov = 1'b0;
            if (clr) blk.delete();
            if (v) begin
                if (blk.size() == 0) begin
                    blk_l = (int'(acc_log) > M) ? M : int'(acc_log);
                    blk_r = round_en;
                end
                blk.push_back(s);
                if (blk.size() == (1 << blk_l)) begin
                    total = 0;
                    foreach (blk[i]) total += blk[i];
                    sh = LC + blk_l;
                    if (blk_r) total += (longint'(1) << sh) / 2;
                    exp_avg = W'(total / (longint'(1) << sh));
                    exp_ov  = 1'b1;
                    blk.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        checks++;
        assert (out_valid === exp_ov) else begin
            errors++;
            $error("FAIL out_valid observed=%0b expected=%0b t=%0t", out_valid, exp_ov, $time);
        end
        checks++;
        assert (avg === exp_avg) else begin
            errors++;
            $error("FAIL avg observed=%0d expected=%0d t=%0t", avg, exp_avg, $time);
        end
        checks++;
        assert (busy === (blk.size() != 0)) else begin
            errors++;
            $error("FAIL busy observed=%0b expected=%0b t=%0t", busy, (blk.size() != 0), $time);
        end
        if (exp_ov || out_valid)
            $display("txn t=%0t avg observed=%0d expected=%0d", $time, avg, exp_avg);
    endtask

    task automatic set_all(input logic [W-1:0] val);
        for (int k = 0; k < C; k++) ch[k] = val;
    endtask

    task automatic set_rand();
        for (int k = 0; k < C; k++) ch[k] = W'($urandom);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            pv[i] = 1'b0;
            ps[i] = 0;
        end
        blk_l = 0;
        blk_r = 1'b0;
        set_all('0);

        // reset with a vector offered: it must be dropped
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (5) tick();

        // channels 1..8, single vector, truncate then round
        for (int k = 0; k < C; k++) ch[k] = W'(k + 1);
        acc_log = 3'd0;
        round_en = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        round_en = 1'b1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();

        // all-ones block of four with rounding
        set_all(16'hFFFF);
        acc_log = 3'd2;
        round_en = 1'b1;
        in_valid = 1'b1;
        repeat (4) tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // ten back-to-back single-vector blocks
        acc_log = 3'd0;
        round_en = 1'b0;
        in_valid = 1'b1;
        for (int v = 1; v <= 10; v++) begin
            for (int k = 0; k < C; k++) ch[k] = W'(v * (k + 1));
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();

        // acc_log change mid-block must not affect the running block
        set_all('0);
        acc_log = 3'd1;
        ch[0] = 16'd16;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        acc_log = 3'd3;
        ch[0] = 16'd32;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // reset mid-block, then a fresh four-vector block
        acc_log = 3'd2;
        in_valid = 1'b1;
        set_rand();
        tick();
        set_rand();
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_rand();
            tick();
        end
        in_valid = 1'b0;
        repeat (6) tick();

        // clr coinciding with an arriving sum starts a new block
        acc_log = 3'd1;
        round_en = 1'b0;
        set_all('0);
        ch[0] = 16'd800;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        ch[0] = 16'd80;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();

        // random traffic with occasional clears and resets
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) set_all(16'hFFFF);
            else set_rand();
            if ($urandom_range(0, 15) == 0) acc_log = 3'($urandom_range(0, 7));
            round_en = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 120) != 0);
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b0;
        rst = 1'b1;
        repeat (8) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
